// File: rtl/dec_10b8b_if.sv
// Symbol-in / byte-out stream bundle for the 8b/10b receive decoder.
// The master side drives symbols and accepts results; the slave side is the decoder.
interface dec_10b8b_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_k;
  logic       out_code_err;
  logic       out_disp_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_k, out_code_err, out_disp_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_k, out_code_err, out_disp_err
  );
endinterface

// File: rtl/dec_10b8b.sv
// Two-stage 8b/10b receive decoder with running-disparity tracking and a saturating error count.
// Define DEC_KCHAR_EN to accept K.28.y and K.23/27/29/30.7 control characters.
module dec_10b8b (
  input  logic        clk,
  input  logic        rst,
  input  logic        err_clr,
  output logic        rd_out,
  output logic [7:0]  err_count,
  dec_10b8b_if.slave  bus
);

  logic       stall;
  logic       accept;
  logic       rd;
  logic [5:0] sb6;
  logic [3:0] sb4;
  logic [3:0] fghj;
  logic [4:0] d6;
  logic [2:0] d4;
  logic       ok6;
  logic       ok4;
  logic       k28;
  logic       a7;
  logic       kx7;
  logic       k_sym;
  logic [2:0] ones6;
  logic [2:0] ones4;
  logic       disp6;
  logic       disp4;
  logic       rd_mid;
  logic       rd_next;

  logic       s1_valid;
  logic [7:0] s1_data;
  logic       s1_k;
  logic       s1_code_err;
  logic       s1_disp_err;

  assign stall       = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~rst;
  assign accept      = bus.in_valid & bus.in_ready;
  assign sb6         = bus.in_data[9:4];
  assign sb4         = bus.in_data[3:0];
  assign rd_out      = rd;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    d6  = 5'd0;
    ok6 = 1'b1;
    k28 = 1'b0;
    case (sb6)
      6'b100111, 6'b011000: d6 = 5'd0;
      6'b011101, 6'b100010: d6 = 5'd1;
      6'b101101, 6'b010010: d6 = 5'd2;
      6'b110001:            d6 = 5'd3;
      6'b110101, 6'b001010: d6 = 5'd4;
      6'b101001:            d6 = 5'd5;
      6'b011001:            d6 = 5'd6;
      6'b111000, 6'b000111: d6 = 5'd7;
      6'b111001, 6'b000110: d6 = 5'd8;
      6'b100101:            d6 = 5'd9;
      6'b010101:            d6 = 5'd10;
      6'b110100:            d6 = 5'd11;
      6'b001101:            d6 = 5'd12;
      6'b101100:            d6 = 5'd13;
      6'b011100:            d6 = 5'd14;
      6'b010111, 6'b101000: d6 = 5'd15;
      6'b011011, 6'b100100: d6 = 5'd16;
      6'b100011:            d6 = 5'd17;
      6'b010011:            d6 = 5'd18;
      6'b110010:            d6 = 5'd19;
      6'b001011:            d6 = 5'd20;
      6'b101010:            d6 = 5'd21;
      6'b011010:            d6 = 5'd22;
      6'b111010, 6'b000101: d6 = 5'd23;
      6'b110011, 6'b001100: d6 = 5'd24;
      6'b100110:            d6 = 5'd25;
      6'b010110:            d6 = 5'd26;
      6'b110110, 6'b001001: d6 = 5'd27;
      6'b001110:            d6 = 5'd28;
      6'b101110, 6'b010001: d6 = 5'd29;
      6'b011110, 6'b100001: d6 = 5'd30;
      6'b101011, 6'b010100: d6 = 5'd31;
`ifdef DEC_KCHAR_EN
      6'b001111, 6'b110000: begin
        d6  = 5'd28;
        k28 = 1'b1;
      end
`endif
      default:              ok6 = 1'b0;
    endcase
  end

  // K.28 at RD+ carries the complement of its RD- 4b code, so undo that before lookup.
  always_comb begin
    fghj  = (k28 && sb6 == 6'b110000) ? ~sb4 : sb4;
    d4    = 3'd0;
    ok4   = 1'b1;
    a7    = 1'b0;
    k_sym = 1'b0;
    case (fghj)
      4'b1011, 4'b0100: d4 = 3'd0;
      4'b1001:          d4 = 3'd1;
      4'b0101:          d4 = 3'd2;
      4'b1100, 4'b0011: d4 = 3'd3;
      4'b1101, 4'b0010: d4 = 3'd4;
      4'b1010:          d4 = 3'd5;
      4'b0110:          d4 = 3'd6;
      4'b1110, 4'b0001: d4 = 3'd7;
      4'b0111, 4'b1000: begin
        d4 = 3'd7;
        a7 = 1'b1;
      end
      default:          ok4 = 1'b0;
    endcase
    kx7 = a7 && (sb6 inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                             6'b101110, 6'b010001, 6'b011110, 6'b100001});
`ifdef DEC_KCHAR_EN
    k_sym = k28 | kx7;
`else
    if (kx7) begin
      ok4 = 1'b0;
      d4  = 3'd0;
    end
`endif
  end

  // Disparity: 6b sub-block checked against the entering RD, 4b against the RD it leaves.
  always_comb begin
    ones6  = 3'($countones(sb6));
    ones4  = 3'($countones(sb4));
    disp6  = 1'b0;
    rd_mid = rd;
    if (ones6 == 3'd4) begin
      disp6  = rd;
      rd_mid = 1'b1;
    end else if (ones6 == 3'd2) begin
      disp6  = ~rd;
      rd_mid = 1'b0;
    end else if (sb6 == 6'b111000) begin
      disp6  = rd;
      rd_mid = 1'b0;
    end else if (sb6 == 6'b000111) begin
      disp6  = ~rd;
      rd_mid = 1'b1;
    end

    disp4   = 1'b0;
    rd_next = rd_mid;
    if (ones4 == 3'd3) begin
      disp4   = rd_mid;
      rd_next = 1'b1;
    end else if (ones4 == 3'd1) begin
      disp4   = ~rd_mid;
      rd_next = 1'b0;
    end else if (sb4 == 4'b1100) begin
      disp4   = rd_mid;
      rd_next = 1'b0;
    end else if (sb4 == 4'b0011) begin
      disp4   = ~rd_mid;
      rd_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so both stages advance from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd               <= 1'b0;
      s1_valid         <= 1'b0;
      s1_data          <= 8'd0;
      s1_k             <= 1'b0;
      s1_code_err      <= 1'b0;
      s1_disp_err      <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= 8'd0;
      bus.out_k        <= 1'b0;
      bus.out_code_err <= 1'b0;
      bus.out_disp_err <= 1'b0;
    end else begin
      if (accept) rd <= rd_next;
      if (!stall) begin
        s1_valid         <= accept;
        s1_data          <= {d4, d6};
        s1_k             <= k_sym;
        s1_code_err      <= ~ok6 | ~ok4;
        s1_disp_err      <= disp6 | disp4;
        bus.out_valid    <= s1_valid;
        bus.out_data     <= s1_data;
        bus.out_k        <= s1_k;
        bus.out_code_err <= s1_code_err;
        bus.out_disp_err <= s1_disp_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err_clr) begin
      err_count <= 8'd0;
    end else if (!stall && s1_valid && (s1_code_err || s1_disp_err) && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dec_10b8b.sv
// Directed bench for dec_10b8b: chained-RD symbol table, saturation/clear, stall and reset sequences.
// Expectations follow DEC_KCHAR_EN when the bench is compiled with it.
module tb_dec_10b8b;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] data;
    logic       k;
    logic       ce;
    logic       de;
    logic       rd;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       err_clr;
  logic       rd_out;
  logic [7:0] err_count;
  int         n_tests;
  int         n_fail;
  int         exp_cnt;

  dec_10b8b_if bus ();

  dec_10b8b dut (
    .clk       (clk),
    .rst       (rst),
    .err_clr   (err_clr),
    .rd_out    (rd_out),
    .err_count (err_count),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // One symbol, then bubbles: checks latency, decoded fields, RD and the error count.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v.sym;
    check($sformatf("in_ready[%0d]", idx), 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check($sformatf("rd_out[%0d]", idx), 32'(rd_out), 32'(v.rd));
    check($sformatf("early_valid[%0d]", idx), 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("out_valid[%0d]", idx), 32'(bus.out_valid), 32'd1);
    check($sformatf("out_data[%0d]", idx), 32'(bus.out_data), 32'(v.data));
    check($sformatf("out_k[%0d]", idx), 32'(bus.out_k), 32'(v.k));
    check($sformatf("code_err[%0d]", idx), 32'(bus.out_code_err), 32'(v.ce));
    check($sformatf("disp_err[%0d]", idx), 32'(bus.out_disp_err), 32'(v.de));
    if ((v.ce || v.de) && exp_cnt < 255) exp_cnt++;
    check($sformatf("err_count[%0d]", idx), 32'(err_count), 32'(exp_cnt));
  endtask

  vec_t       vecs[16];
  logic [9:0] syms[6];
  logic [7:0] exp_bytes[6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    rst     = 1'b1;
    err_clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 10'd0;
    bus.out_ready = 1'b1;

    // Chained stream from reset: each row's RD follows from the previous row.
    vecs[0]  = '{10'h274, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{10'h18B, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{10'h18B, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{10'h319, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{10'h237, 8'hF1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{10'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{10'h071, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef DEC_KCHAR_EN
    vecs[7]  = '{10'h3A8, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{10'h0FA, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{10'h305, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    vecs[7]  = '{10'h3A8, 8'h17, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{10'h0FA, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{10'h305, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    vecs[10] = '{10'h15A, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{10'h15F, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{10'h3CA, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{10'h274, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{10'h31C, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{10'h313, 8'h63, 1'b0, 1'b0, 1'b1, 1'b1};

    // RD-neutral symbols for the back-to-back stall stream.
    syms[0] = 10'h319; exp_bytes[0] = 8'h23;
    syms[1] = 10'h295; exp_bytes[1] = 8'h45;
    syms[2] = 10'h19A; exp_bytes[2] = 8'hA6;
    syms[3] = 10'h256; exp_bytes[3] = 8'hC9;
    syms[4] = 10'h159; exp_bytes[4] = 8'h2A;
    syms[5] = 10'h34A; exp_bytes[5] = 8'hAB;

    // Reset state
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    do_reset();

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Saturation: 300 back-to-back code errors
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'h000;
    repeat (300) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("err_saturate", 32'(err_count), 32'd255);

    // Clear collides with an error advancing into S2
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_code_err", 32'(bus.out_code_err), 32'd1);
    check("clr_priority", 32'(err_count), 32'd0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("count_after_clr", 32'(err_count), 32'd1);

    // Stall: out_ready low for 5 cycles while in_valid stays high
    begin
      int   tx;
      int   rx;
      logic held_valid;
      logic [7:0] held_data;
      logic was_stall;
      tx = 0;
      rx = 0;
      was_stall  = 1'b0;
      held_valid = 1'b0;
      held_data  = 8'd0;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        bus.out_ready = !(c >= 4 && c < 9);
        bus.in_valid  = (tx < 6);
        bus.in_data   = (tx < 6) ? syms[tx] : 10'd0;
        #1;
        if (was_stall) begin
          check($sformatf("hold_valid[%0d]", c), 32'(bus.out_valid), 32'(held_valid));
          check($sformatf("hold_data[%0d]", c), 32'(bus.out_data), 32'(held_data));
        end
        if (c == 8) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
          if (rx < 6) check($sformatf("stream[%0d]", rx), 32'(bus.out_data), 32'(exp_bytes[rx]));
          else check("extra_output", 32'd1, 32'd0);
          rx++;
        end
        was_stall  = bus.out_valid & ~bus.out_ready;
        held_valid = bus.out_valid;
        held_data  = bus.out_data;
        if (bus.in_valid && bus.in_ready) tx++;
      end
      check("stream_sent", 32'(tx), 32'd6);
      check("stream_recv", 32'(rx), 32'd6);
    end

    // Reset mid-stream
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = syms[5];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_rd", 32'(rd_out), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    apply(vecs[1], 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
